// File: rtl/lfsr_pkg.sv
// ============================================================================
// lfsr_pkg : shared widths, defaults and FSM encoding for the LFSR controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package lfsr_pkg;

    localparam int LFSR_W        = 8;
    localparam int DB_CYCLES_DEF = 500000;
    localparam int AUTO_DIV_DEF  = 25000000;

    typedef enum logic [2:0] {
        ST_EMPTY  = 3'd0,
        ST_LOAD   = 3'd1,
        ST_READY  = 3'd2,
        ST_STEP   = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lfsr_step_ctrl_if.sv
// ============================================================================
// lfsr_step_ctrl_if : board I/O and LFSR datapath signals of the controller
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lfsr_step_ctrl_if;
    import lfsr_pkg::*;

    logic              btn_step;
    logic              btn_load;
    logic              sw_auto;
    logic [LFSR_W-1:0] sw_seed;
    logic [LFSR_W-1:0] coda_in;
    logic              step_en;
    logic              load_en;
    logic [LFSR_W-1:0] seed_out;
    logic [7:0]        steps;
    logic              period_done;
    logic              seed_err;
    logic              ready;

    modport master (
        input  btn_step, btn_load, sw_auto, sw_seed, coda_in,
        output step_en, load_en, seed_out, steps, period_done, seed_err, ready
    );

    modport slave (
        output btn_step, btn_load, sw_auto, sw_seed, coda_in,
        input  step_en, load_en, seed_out, steps, period_done, seed_err, ready
    );

endinterface

`default_nettype wire

// File: rtl/lfsr_step_ctrl_btn_debounce.sv
// ============================================================================
// btn_debounce : 2-flop synchroniser, stability counter, rising-edge pulse
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int             c_cw      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [c_cw-1:0] r_cnt;

    // The debounced level only flips after the synchronised input has
    // differed from it for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            pulse   <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            pulse   <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                pulse   <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lfsr_step_ctrl.sv
// ============================================================================
// lfsr_step_ctrl : step/load strobe sequencer and period tracker for 8-bit LFSR
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int AUTO_DIV  = AUTO_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    lfsr_step_ctrl_if.master bus
);

    localparam int              c_dw      = $clog2(AUTO_DIV);
    localparam logic [c_dw-1:0] c_div_max = c_dw'(AUTO_DIV - 1);

    state_t            r_state;
    logic              r_step_en;
    logic              r_load_en;
    logic              r_seed_err;
    logic              r_ready;
    logic [LFSR_W-1:0] r_seed;
    logic [7:0]        r_steps;
    logic              r_pend;
    logic [LFSR_W-1:0] r_pend_seed;
    logic [c_dw-1:0]   r_div;

    logic w_step_p;
    logic w_load_p;
    logic w_load_ok;
    logic w_load_bad;
    logic w_div_run;
    logic w_tick;
    logic w_step_req;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.btn_step),
        .pulse (w_step_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.btn_load),
        .pulse (w_load_p)
    );

    assign w_load_ok  = w_load_p && (bus.sw_seed != '0);
    assign w_load_bad = w_load_p && (bus.sw_seed == '0);

    // Divider keeps running through STEP/SETTLE so auto steps stay exactly
    // AUTO_DIV cycles apart; EMPTY and LOAD hold it cleared.
    assign w_div_run  = bus.sw_auto &&
                        ((r_state == ST_READY) || (r_state == ST_STEP) || (r_state == ST_SETTLE));
    assign w_tick     = w_div_run && (r_div == c_div_max);
    assign w_step_req = bus.sw_auto ? w_tick : w_step_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (!w_div_run || (r_div == c_div_max)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_step_en   <= 1'b0;
            r_load_en   <= 1'b0;
            r_seed_err  <= 1'b0;
            r_ready     <= 1'b0;
            r_seed      <= '0;
            r_steps     <= '0;
            r_pend      <= 1'b0;
            r_pend_seed <= '0;
        end else begin
            r_step_en  <= 1'b0;
            r_load_en  <= 1'b0;
            r_seed_err <= w_load_bad;
            case (r_state)
                ST_EMPTY: begin
                    if (w_load_ok) begin
                        r_state   <= ST_LOAD;
                        r_load_en <= 1'b1;
                        r_seed    <= bus.sw_seed;
                        r_steps   <= '0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_READY;
                    r_ready <= 1'b1;
                end
                ST_READY: begin
                    if (w_load_ok || r_pend) begin
                        r_state   <= ST_LOAD;
                        r_ready   <= 1'b0;
                        r_load_en <= 1'b1;
                        r_seed    <= w_load_ok ? bus.sw_seed : r_pend_seed;
                        r_steps   <= '0;
                        r_pend    <= 1'b0;
                    end else if (!w_load_bad && w_step_req) begin
                        r_state   <= ST_STEP;
                        r_ready   <= 1'b0;
                        r_step_en <= 1'b1;
                    end
                end
                ST_STEP: begin
                    r_state <= ST_SETTLE;
                    r_steps <= r_steps + 8'd1;
                    if (w_load_ok) begin
                        r_pend      <= 1'b1;
                        r_pend_seed <= bus.sw_seed;
                    end
                end
                ST_SETTLE: begin
                    r_state <= ST_READY;
                    r_ready <= 1'b1;
                    if (w_load_ok) begin
                        r_pend      <= 1'b1;
                        r_pend_seed <= bus.sw_seed;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.step_en  = r_step_en;
    assign bus.load_en  = r_load_en;
    assign bus.seed_err = r_seed_err;
    assign bus.ready    = r_ready;
    assign bus.seed_out = r_seed;
    assign bus.steps    = r_steps;

    // The datapath has only shifted by the SETTLE cycle, so the period
    // compare must look at coda_in during SETTLE itself.
    assign bus.period_done = (r_state == ST_SETTLE) && (bus.coda_in == r_seed);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_step_ctrl.sv
// ============================================================================
// tb_lfsr_step_ctrl : bench for lfsr_step_ctrl with an 8-bit LFSR datapath model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_step_ctrl;
    import lfsr_pkg::*;

    localparam int DB = 4;
    localparam int AD = 8;

    localparam int EV_NONE = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_STEP = 2;
    localparam int EV_ERR  = 3;

    localparam int OP_LOAD   = 0;
    localparam int OP_STEP   = 1;
    localparam int OP_GLITCH = 2;
    localparam int NV        = 9;

    typedef struct {
        int         op;
        logic [7:0] seed;
        int         hold;
        int         exp_ev;
    } vec_t;

    typedef struct {
        int         ev;
        logic [7:0] seed;
        logic [7:0] steps;
        logic       pd;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] coda;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_step_cyc = 0;
    int   last_load_cyc = 0;
    int   steps_seen = 0;
    bit   settle_pend = 1'b0;
    bit   last_step_ok = 1'b0;
    exp_t settle_e;
    exp_t mon_e;
    exp_t exp_q[$];
    vec_t tv[NV];

    logic [7:0] m_seed = 8'h00;
    logic [7:0] m_lfsr = 8'h00;
    logic [7:0] m_steps = 8'h00;

    lfsr_step_ctrl_if bus ();

    lfsr_step_ctrl #(.DB_CYCLES(DB), .AUTO_DIV(AD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Datapath: maximal-length Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           coda <= 8'h00;
        else if (bus.load_en) coda <= bus.seed_out;
        else if (bus.step_en) coda <= lfsr_next(coda);
    end
    assign bus.coda_in = coda;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_load(input logic [7:0] s);
        exp_t e;
        e.ev = EV_LOAD; e.seed = s; e.steps = 8'h00; e.pd = 1'b0; e.rdy = 1'b0;
        exp_q.push_back(e);
        m_seed = s; m_lfsr = s; m_steps = 8'h00;
    endtask

    task automatic exp_step();
        exp_t e;
        m_lfsr  = lfsr_next(m_lfsr);
        m_steps = m_steps + 8'd1;
        e.ev = EV_STEP; e.seed = m_seed; e.steps = m_steps;
        e.pd = (m_lfsr == m_seed); e.rdy = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.ev = EV_ERR; e.seed = m_seed; e.steps = m_steps; e.pd = 1'b0;
        e.rdy = (m_seed != 8'h00);
        exp_q.push_back(e);
    endtask

    task automatic press(input int op, input int hold);
        @(posedge clk); #1;
        if (op == OP_LOAD) bus.btn_load = 1'b1;
        else               bus.btn_step = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.btn_load = 1'b0;
        bus.btn_step = 1'b0;
        repeat (DB + 10) @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: every strobe pops the oldest expected event
    always @(negedge clk) begin
        if (!rst_n) begin
            settle_pend  = 1'b0;
            last_step_ok = 1'b0;
        end else begin
            if (settle_pend) begin
                chk("settle_steps", int'(bus.steps), int'(settle_e.steps));
                chk("period_done", int'(bus.period_done), int'(settle_e.pd));
                settle_pend = 1'b0;
            end else begin
                chk("period_done_idle", int'(bus.period_done), 0);
            end
            if (!bus.sw_auto) last_step_ok = 1'b0;
            if (bus.load_en) begin
                chk("load_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("load_kind", mon_e.ev, EV_LOAD);
                    chk("load_seed", int'(bus.seed_out), int'(mon_e.seed));
                    chk("load_steps", int'(bus.steps), 0);
                end
                last_load_cyc = cyc;
            end
            if (bus.step_en) begin
                chk("step_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("step_kind", mon_e.ev, EV_STEP);
                    settle_e    = mon_e;
                    settle_pend = 1'b1;
                end
                if (last_step_ok) chk("auto_spacing", cyc - last_step_cyc, AD);
                last_step_cyc = cyc;
                last_step_ok  = bus.sw_auto;
                steps_seen++;
            end
            if (bus.seed_err) begin
                chk("err_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("err_kind", mon_e.ev, EV_ERR);
                    chk("err_seed", int'(bus.seed_out), int'(mon_e.seed));
                    chk("err_ready", int'(bus.ready), int'(mon_e.rdy));
                end
            end
        end
    end

    initial begin
        int tgt;
        int w;

        tv[0] = '{OP_LOAD,   8'h5A, 8,  EV_LOAD};
        tv[1] = '{OP_STEP,   8'h00, 8,  EV_STEP};
        tv[2] = '{OP_STEP,   8'h00, 8,  EV_STEP};
        tv[3] = '{OP_STEP,   8'h00, 30, EV_STEP};
        tv[4] = '{OP_GLITCH, 8'h00, 2,  EV_NONE};
        tv[5] = '{OP_LOAD,   8'h00, 8,  EV_ERR};
        tv[6] = '{OP_STEP,   8'h00, 8,  EV_STEP};
        tv[7] = '{OP_LOAD,   8'hC3, 8,  EV_LOAD};
        tv[8] = '{OP_STEP,   8'h00, 8,  EV_STEP};

        bus.btn_step = 1'b0;
        bus.btn_load = 1'b0;
        bus.sw_auto  = 1'b0;
        bus.sw_seed  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_step_en", int'(bus.step_en), 0);
        chk("rst_load_en", int'(bus.load_en), 0);
        chk("rst_seed_out", int'(bus.seed_out), 0);
        chk("rst_steps", int'(bus.steps), 0);
        chk("rst_ready", int'(bus.ready), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("empty_ready", int'(bus.ready), 0);

        for (int i = 0; i < NV; i++) begin
            if (tv[i].op == OP_LOAD) bus.sw_seed = tv[i].seed;
            case (tv[i].exp_ev)
                EV_LOAD: exp_load(tv[i].seed);
                EV_STEP: exp_step();
                EV_ERR:  exp_err();
                default: ;
            endcase
            press((tv[i].op == OP_LOAD) ? OP_LOAD : OP_STEP, tv[i].hold);
            chk("vec_seed_out", int'(bus.seed_out), int'(m_seed));
            chk("vec_steps", int'(bus.steps), int'(m_steps));
            chk("vec_ready", int'(bus.ready), int'(m_seed != 8'h00));
            chk("vec_drained", exp_q.size(), 0);
        end

        // Auto run: 256 ticks from seed 01 covers one full period plus wrap
        bus.sw_seed = 8'h01;
        exp_load(8'h01);
        press(OP_LOAD, 8);
        for (int k = 0; k < 256; k++) exp_step();
        tgt = steps_seen + 256;
        @(posedge clk); #1;
        bus.sw_auto = 1'b1;
        w = 0;
        while (steps_seen < tgt && w < 256 * AD + 64) begin
            @(negedge clk);
            w++;
        end
        bus.sw_auto = 1'b0;
        chk("auto_step_count", steps_seen - (tgt - 256), 256);
        repeat (4) @(negedge clk);
        chk("auto_drained", exp_q.size(), 0);
        chk("auto_steps_wrap", int'(bus.steps), 0);

        // Load press landing in STEP is held and serviced after SETTLE
        bus.sw_seed = 8'hA7;
        exp_step();
        exp_load(8'hA7);
        @(posedge clk); #1;
        bus.btn_step = 1'b1;
        @(posedge clk); #1;
        bus.btn_load = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        bus.btn_step = 1'b0;
        bus.btn_load = 1'b0;
        repeat (DB + 10) @(posedge clk);
        @(negedge clk);
        chk("pend_latency", last_load_cyc - last_step_cyc, 3);
        chk("pend_seed_out", int'(bus.seed_out), 8'hA7);
        chk("pend_steps", int'(bus.steps), 0);
        chk("pend_drained", exp_q.size(), 0);

        // Asynchronous reset asserted in the SETTLE cycle
        exp_step();
        @(posedge clk); #1;
        bus.btn_step = 1'b1;
        w = 0;
        while (!bus.step_en && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("rst_step_seen", int'(bus.step_en), 1);
        bus.btn_step = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_step_en", int'(bus.step_en), 0);
        chk("arst_load_en", int'(bus.load_en), 0);
        chk("arst_seed_out", int'(bus.seed_out), 0);
        chk("arst_steps", int'(bus.steps), 0);
        chk("arst_period_done", int'(bus.period_done), 0);
        chk("arst_seed_err", int'(bus.seed_err), 0);
        chk("arst_ready", int'(bus.ready), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_seed = 8'h00; m_lfsr = 8'h00; m_steps = 8'h00;
        press(OP_STEP, 8);
        chk("empty_drop_ready", int'(bus.ready), 0);
        chk("empty_drop_steps", int'(bus.steps), 0);
        bus.sw_seed = 8'h5A;
        exp_load(8'h5A);
        press(OP_LOAD, 8);
        chk("reload_ready", int'(bus.ready), 1);
        chk("reload_seed_out", int'(bus.seed_out), 8'h5A);
        chk("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
